forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Tracks in-flight register writers in a FWD_DEPTH-deep shadow pipeline that shifts every clock.
- For each of NUM_RD_PORTS source operands it produces a forward-select naming the youngest in-flight producer.
- Raises a load-use stall when that producer's data is not yet available. Sits beside the issue stage (ID→EX boundary) and drives the operand bypass muxes and pipeline stall.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- NUM_RD_PORTS, 2, number of source-operand ports checked.
- FWD_DEPTH, 3, number of tracked stages after issue (1=EX, 2=MEM, 3=WB).
- LOAD_READY_STAGE, 2, first stage index at which load data can be forwarded; legal range 1..FWD_DEPTH.
- CNT_WIDTH, 16, width of stall statistics counter.
- SEL_W (localparam) = $clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- issue_valid  in  1  instruction present in issue stage.
- issue_reg_wr_en  in  1  issuing instruction writes rd.
- issue_is_load  in  1  issuing instruction is a load.
- issue_rd  in  REG_ADDR_WIDTH  destination of issuing instruction.
- rs_addr  in  NUM_RD_PORTS*REG_ADDR_WIDTH  packed source addresses; port p at bits [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- rs_used  in  NUM_RD_PORTS  per-port "operand actually read" mask.
- flush  in  1  squash the instruction currently in stage 1.
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per-port select; 0 = register file, k = stage k result.
- stall  out  1  hold issue stage, insert bubble.
- stall_count  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- State per stage k (1..FWD_DEPTH): valid, wr_en, is_load, rd. Reset clears all valid bits; stall_count resets to 0.
- Valid entry k "writes" iff valid & wr_en & rd != 0. x0 never matches.
- fwd_sel is combinational from current state and rs inputs:
  - Port p is selected to the smallest k whose writing entry's rd == rs_addr[p].
  - Port p gets 0 if rs_used[p] = 0 or no writing entry matches.
  - Youngest wins: a stage-1 match beats stage 2, and so on.
- Port hazard:
  - Occurs when the selected entry has is_load = 1 and k < LOAD_READY_STAGE.
  - Older matches are NOT consulted in that case; the port's fwd_sel still reports k.
- stall (combinational) = issue_valid & (OR of port hazards). stall = 0 whenever issue_valid = 0.
- Issue fire = issue_valid & ~stall.
- Per clock, shift: stage k+1 <= stage k for k = 1..FWD_DEPTH-1. The stage-FWD_DEPTH entry retires.
- Stage 1 load, per clock:
  - If fire & ~flush, stage 1 <= {1, issue_reg_wr_en, issue_is_load, issue_rd}.
  - Otherwise stage 1 <= bubble (valid = 0).
- flush: the stage-1 entry's valid is forced to 0 as it shifts into stage 2 (squashed instruction never forwards downstream). The issue-stage instruction in the same cycle is also dropped.
- flush and stall in the same cycle: flush wins; a bubble is inserted and stall_count still increments.
- stall_count: +1 each cycle stall = 1; saturates at 2^CNT_WIDTH-1, no wrap.
- Latency: a producer issued in cycle N is visible at stage 1 in cycle N+1. A dependent load-use with LOAD_READY_STAGE = 2 stalls exactly 1 cycle.
- Reset asserted mid-operation: all entries invalid immediately (async), fwd_sel = 0, stall = 0. Normal operation resumes on the first clock after deassertion.

Test Plan:
- Reset with rs_addr = {5'd3, 5'd3}, rs_used = 2'b11 -> fwd_sel = 0 and stall = 0 for both ports; stall_count = 0.
- ALU chain: issue add x5 (wr_en = 1); next cycle rs1 = x5, rs_used = 01 -> port0 fwd_sel = 1, stall = 0. One cycle later (intervening nop) -> fwd_sel = 2. Then 3. Then 0.
- Load-use: issue lw x7; next cycle rs1 = x7 -> stall = 1 for exactly one cycle, stall_count = 1. The next cycle has fwd_sel = 2, stall = 0, and stage 1 holds a bubble.
- Priority/x0:
  - add x4 followed by sub x4 -> fwd_sel = 1 (younger).
  - add x0 then read x0 -> fwd_sel = 0.
  - rs_used = 0 with a matching rd -> fwd_sel = 0.
- Flush: issue add x9, assert flush next cycle -> in the following cycle rs = x9 gives fwd_sel = 0 (no stage matches). flush coincident with a load-use stall -> bubble inserted, stall_count increments.
- Saturation: CNT_WIDTH = 4, hold a load-use hazard for 20 cycles (repeated lw to same rd) -> stall_count stops at 15. Async reset pulse mid-stall -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers in a shifting
// shadow pipeline beside the issue stage, picks the youngest producer for
// each source operand and raises a load-use stall when that producer's
// data is not yet available.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   issue_valid       instruction present in the issue stage
//   issue_reg_wr_en   issuing instruction writes rd
//   issue_is_load     issuing instruction is a load
//   issue_rd          destination register of the issuing instruction
//   rs_addr           packed source addresses, port p at [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   rs_used           per-port operand-read mask
//   flush             squash the instruction currently in stage 1
//   fwd_sel           per-port bypass select, 0 = register file, k = stage k
//   stall             hold the issue stage and insert a bubble
//   stall_count       saturating count of stalled cycles
module forwarding_scoreboard #(
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned NUM_RD_PORTS     = 2,
  parameter int unsigned FWD_DEPTH        = 3,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned CNT_WIDTH        = 16,
  localparam int unsigned SEL_W           = $clog2(FWD_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   issue_valid,
  input  logic                                   issue_reg_wr_en,
  input  logic                                   issue_is_load,
  input  logic [REG_ADDR_WIDTH-1:0]              issue_rd,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [NUM_RD_PORTS-1:0]                rs_used,
  input  logic                                   flush,
  output logic [NUM_RD_PORTS*SEL_W-1:0]          fwd_sel,
  output logic                                   stall,
  output logic [CNT_WIDTH-1:0]                   stall_count
);

  // Shadow pipeline; index 0 is stage 1 (EX).
  logic [FWD_DEPTH-1:0]      stg_valid;
  logic [FWD_DEPTH-1:0]      stg_wr_en;
  logic [FWD_DEPTH-1:0]      stg_is_load;
  logic [REG_ADDR_WIDTH-1:0] stg_rd [FWD_DEPTH];

  logic [FWD_DEPTH-1:0]      stg_writes;
  logic [FWD_DEPTH-1:0]      stg_early;
  logic [FWD_DEPTH-1:0]      valid_shift;
  logic [NUM_RD_PORTS-1:0]   port_hazard;
  logic                      fire;

  // Per-stage static flags: does the entry write a real register, and is
  // the stage too early for load data to be forwarded.
  for (genvar k = 0; k < int'(FWD_DEPTH); k++) begin : g_stage
    localparam int unsigned STAGE_IDX = k + 1;
    assign stg_writes[k] = stg_valid[k] & stg_wr_en[k] & (stg_rd[k] != '0);
    assign stg_early[k]  = 1'(STAGE_IDX < LOAD_READY_STAGE);
  end

  // Youngest-match select per port; scanning old-to-young lets the youngest
  // match overwrite. The hazard follows the selected entry only.
  always_comb begin
    fwd_sel     = '0;
    port_hazard = '0;
    for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
      for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
        if (rs_used[p] && stg_writes[k] &&
            (stg_rd[k] == rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
          port_hazard[p]            = stg_is_load[k] & stg_early[k];
        end
      end
    end
  end

  assign stall = issue_valid & (|port_hazard);
  assign fire  = issue_valid & ~stall;

  // A flushed stage-1 entry loses its valid bit as it moves to stage 2.
  always_comb begin
    valid_shift    = stg_valid;
    valid_shift[0] = stg_valid[0] & ~flush;
  end

  // Shadow pipeline shift and stage-1 load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid   <= '0;
      stg_wr_en   <= '0;
      stg_is_load <= '0;
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        stg_rd[k] <= '0;
      end
    end else begin
      for (int k = int'(FWD_DEPTH) - 1; k > 0; k--) begin
        stg_valid[k]   <= valid_shift[k-1];
        stg_wr_en[k]   <= stg_wr_en[k-1];
        stg_is_load[k] <= stg_is_load[k-1];
        stg_rd[k]      <= stg_rd[k-1];
      end
      stg_valid[0]   <= fire & ~flush;
      stg_wr_en[0]   <= issue_reg_wr_en;
      stg_is_load[0] <= issue_is_load;
      stg_rd[0]      <= issue_rd;
    end
  end

  // Saturating stall statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed self-checking bench for forwarding_scoreboard. A second instance
// with a 4-bit stall counter shares all inputs to exercise saturation.
module tb_forwarding_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_reg_wr_en;
  logic        issue_is_load;
  logic [4:0]  issue_rd;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_used;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;
  logic [3:0]  fwd_sel_s;
  logic        stall_s;
  logic [3:0]  stall_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  forwarding_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_reg_wr_en(issue_reg_wr_en), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .rs_addr(rs_addr), .rs_used(rs_used), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  forwarding_scoreboard #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_reg_wr_en(issue_reg_wr_en), .issue_is_load(issue_is_load),
    .issue_rd(issue_rd), .rs_addr(rs_addr), .rs_used(rs_used), .flush(flush),
    .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one issue-stage vector, then settle before sampling.
  task automatic drive(input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used);
    issue_valid     = v;
    issue_reg_wr_en = wr;
    issue_is_load   = ld;
    issue_rd        = rd;
    rs_addr         = {rs1, rs0};
    rs_used         = used;
    #1;
  endtask

  // Advance one clock; inputs change and outputs are sampled after the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 2'b11);
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL reset_sel got %0d exp 0", fwd_sel); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall); else n_pass++;
    n_checks++; if (stall_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", stall_count); else n_pass++;
    n_checks++; if (stall_count_s !== 4'd0) $display("FAIL reset_count_sat got %0d exp 0", stall_count_s); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drain();
  endtask

  task automatic test_alu_chain();
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00);   // add x5
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 2'b01);   // reader of x5, no write
    n_checks++; if (fwd_sel !== 4'd1) $display("FAIL alu_sel_ex got %0d exp 1", fwd_sel); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL alu_stall got %0b exp 0", stall); else n_pass++;
    step();
    n_checks++; if (fwd_sel !== 4'd2) $display("FAIL alu_sel_mem got %0d exp 2", fwd_sel); else n_pass++;
    step();
    n_checks++; if (fwd_sel !== 4'd3) $display("FAIL alu_sel_wb got %0d exp 3", fwd_sel); else n_pass++;
    step();
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL alu_sel_retired got %0d exp 0", fwd_sel); else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);   // lw x7
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd7, 2'b01);   // add x8 <- x7
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall got %0b exp 1", stall); else n_pass++;
    n_checks++; if (fwd_sel !== 4'd1) $display("FAIL lu_sel_stalled got %0d exp 1", fwd_sel); else n_pass++;
    step();
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_release got %0b exp 0", stall); else n_pass++;
    n_checks++; if (fwd_sel !== 4'd2) $display("FAIL lu_sel_mem got %0d exp 2", fwd_sel); else n_pass++;
    n_checks++; if (stall_count !== 16'd1) $display("FAIL lu_count got %0d exp 1", stall_count); else n_pass++;
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd8, 2'b11);   // add x8 fired once, lw behind a bubble
    n_checks++; if (fwd_sel !== 4'b1101) $display("FAIL lu_after got %b exp 1101", fwd_sel); else n_pass++;
    n_checks++; if (stall_count !== 16'd1) $display("FAIL lu_count_hold got %0d exp 1", stall_count); else n_pass++;
    drain();
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00);   // add x4
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 2'b00);   // sub x4
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 2'b01);   // add x0, reads x4
    n_checks++; if (fwd_sel !== 4'd1) $display("FAIL prio_young got %0d exp 1", fwd_sel); else n_pass++;
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b11);   // read x0 and x4
    n_checks++; if (fwd_sel !== 4'b1000) $display("FAIL prio_x0 got %b exp 1000", fwd_sel); else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd4, 2'b00);
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL prio_unused got %0d exp 0", fwd_sel); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 2'b00);   // add x9
    step();
    flush = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    step();
    flush = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 2'b01);
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL flush_sel got %0d exp 0", fwd_sel); else n_pass++;
    drain();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);   // lw x7
    step();
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd7, 2'b01);
    n_checks++; if (stall !== 1'b1) $display("FAIL flush_stall got %0b exp 1", stall); else n_pass++;
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall_after got %0b exp 0", stall); else n_pass++;
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL flush_lw_squashed got %0d exp 0", fwd_sel); else n_pass++;
    n_checks++; if (stall_count !== 16'd2) $display("FAIL flush_count got %0d exp 2", stall_count); else n_pass++;
    drain();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    // Repeated lw x7 <- x7: stalls every other cycle, 20 stalls in 40 cycles.
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 2'b01);
    repeat (40) step();
    n_checks++; if (stall_count !== 16'd20) $display("FAIL sat_wide got %0d exp 20", stall_count); else n_pass++;
    n_checks++; if (stall_count_s !== 4'd15) $display("FAIL sat_narrow got %0d exp 15", stall_count_s); else n_pass++;
    step();
    n_checks++; if (stall !== 1'b1) $display("FAIL sat_in_stall got %0b exp 1", stall); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL async_stall got %0b exp 0", stall); else n_pass++;
    n_checks++; if (stall_s !== 1'b0) $display("FAIL async_stall_sat got %0b exp 0", stall_s); else n_pass++;
    n_checks++; if (fwd_sel !== 4'd0) $display("FAIL async_sel got %0d exp 0", fwd_sel); else n_pass++;
    n_checks++; if (stall_count !== 16'd0) $display("FAIL async_count got %0d exp 0", stall_count); else n_pass++;
    n_checks++; if (stall_count_s !== 4'd0) $display("FAIL async_count_sat got %0d exp 0", stall_count_s); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 2'b00);   // add x6 after reset
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 2'b01);
    n_checks++; if (fwd_sel !== 4'd1) $display("FAIL resume_sel got %0d exp 1", fwd_sel); else n_pass++;
    drain();
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    issue_valid     = 1'b0;
    issue_reg_wr_en = 1'b0;
    issue_is_load   = 1'b0;
    issue_rd        = '0;
    rs_addr         = '0;
    rs_used         = '0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
